axi_sram: RTL and testbench

AXI_SRAM -- requirements
Module: axi_sram

---
 rtl/axi_sram_if.sv | 31 +++
 rtl/axi_sram.sv | 193 +++++++++++++++++++
 tb/tb_axi_sram.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_if.sv
// AXI4-Lite style single-beat bus bundle between an initiator and the axi_sram target.
// Only the address, data, strobe and response fields used by the SRAM are carried.
interface axi_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_sram.sv
// Single-outstanding AXI-Lite SRAM target with programmable response latency.
// Out-of-range accesses complete with SLVERR and never touch memory.
module axi_sram #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_sram_if.slave   s_axi
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0]  LAT   = 8'(LATENCY);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WR_NEED_AW = 3'd1;
    localparam logic [2:0] S_WR_NEED_W  = 3'd2;
    localparam logic [2:0] S_RD_WAIT    = 3'd3;
    localparam logic [2:0] S_RD_RESP    = 3'd4;
    localparam logic [2:0] S_WR_WAIT    = 3'd5;
    localparam logic [2:0] S_WR_RESP    = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Unsigned wrap-around subtraction also rejects addresses below BASE.
    function automatic logic in_range(input logic [31:0] addr);
        logic [32:0] off;
        off = {1'b0, addr - BASE};
        return off < (33'd4 << DEPTH_LOG2);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return DEPTH_LOG2'(off >> 2);
    endfunction

    logic [31:0]           r_mem [DEPTH];
    logic [2:0]            r_state;
    logic [7:0]            r_cnt;
    logic                  r_rdy_en;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rvalid;
    logic [1:0]            r_bresp;
    logic                  r_bvalid;

    logic                  w_idle;
    logic                  w_arready;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_ar_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_e0;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_wr_commit;
    logic [31:0]           w_rd_addr;
    logic [31:0]           w_wr_addr;
    logic [31:0]           w_wr_data;
    logic [3:0]            w_wr_strb;

    // Channel readiness, handshakes and the edge on which each response fires.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_arready = 1'b0;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        if (r_rdy_en) begin
            w_arready = w_idle;
            w_awready = (w_idle && !s_axi.arvalid) || (r_state == S_WR_NEED_AW);
            w_wready  = (w_idle && !s_axi.arvalid) || (r_state == S_WR_NEED_W);
        end else begin
            w_arready = 1'b0;
            w_awready = 1'b0;
            w_wready  = 1'b0;
        end
        w_ar_hs = w_arready && s_axi.arvalid;
        w_aw_hs = w_awready && s_axi.awvalid;
        w_w_hs  = w_wready  && s_axi.wvalid;
        w_wr_e0 = (w_idle && w_aw_hs && w_w_hs)
                || ((r_state == S_WR_NEED_AW) && w_aw_hs)
                || ((r_state == S_WR_NEED_W)  && w_w_hs);
        w_rd_fire = ((LAT == 8'd0) && w_ar_hs) || ((r_state == S_RD_WAIT) && (r_cnt == 8'd1));
        w_wr_fire = ((LAT == 8'd0) && w_wr_e0) || ((r_state == S_WR_WAIT) && (r_cnt == 8'd1));
        // With zero latency the response uses the values arriving on this very edge.
        w_rd_addr   = w_ar_hs ? s_axi.araddr : r_addr;
        w_wr_addr   = w_aw_hs ? s_axi.awaddr : r_addr;
        w_wr_data   = w_w_hs  ? s_axi.wdata  : r_wdata;
        w_wr_strb   = w_w_hs  ? s_axi.wstrb  : r_wstrb;
        w_wr_commit = w_wr_fire && in_range(w_wr_addr);
    end

    // Transaction sequencing, request capture and latency countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_rdy_en <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_aw_hs) r_addr <= s_axi.awaddr;
            if (w_ar_hs) r_addr <= s_axi.araddr;
            if (w_w_hs) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        r_cnt   <= LAT;
                        r_state <= (LAT == 8'd0) ? S_RD_RESP : S_RD_WAIT;
                    end else if (w_wr_e0) begin
                        r_cnt   <= LAT;
                        r_state <= (LAT == 8'd0) ? S_WR_RESP : S_WR_WAIT;
                    end else if (w_aw_hs) begin
                        r_state <= S_WR_NEED_W;
                    end else if (w_w_hs) begin
                        r_state <= S_WR_NEED_AW;
                    end
                end
                S_WR_NEED_AW, S_WR_NEED_W: begin
                    if (w_wr_e0) begin
                        r_cnt   <= LAT;
                        r_state <= (LAT == 8'd0) ? S_WR_RESP : S_WR_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) r_state <= S_RD_RESP;
                end
                S_WR_WAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) r_state <= S_WR_RESP;
                end
                S_RD_RESP: if (s_axi.rready) r_state <= S_IDLE;
                S_WR_RESP: if (s_axi.bready) r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Response registers: loaded on the fire edge, held until the initiator takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_bvalid <= 1'b0;
        end else begin
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= in_range(w_rd_addr) ? r_mem[word_idx(w_rd_addr)] : 32'd0;
                r_rresp  <= in_range(w_rd_addr) ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && s_axi.rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= in_range(w_wr_addr) ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axi.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Storage array; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_strb[i]) r_mem[word_idx(w_wr_addr)][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
        end
    end

    assign s_axi.arready = w_arready;
    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.bvalid  = r_bvalid;
endmodule

// File: tb/tb_axi_sram.sv
// Directed bench for axi_sram (DEPTH_LOG2=12, BASE=0x8000_0000, LATENCY=1).
module tb_axi_sram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    axi_sram_if bus();

    axi_sram #(.DEPTH_LOG2(12), .BASE(32'h8000_0000), .LATENCY(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int lat, output logic [1:0] resp);
        int n;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(bus.awready && bus.wready) && n < 20) begin @(negedge clk); n++; end
        chk("wr_accept", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.bvalid && lat < 20) begin @(negedge clk); lat++; end
        resp = bus.bresp;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        chk("rd_accept", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.rvalid && lat < 20) begin @(negedge clk); lat++; end
        d = bus.rdata; resp = bus.rresp;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        int          lat;
        bus.araddr = 32'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = 32'd0; bus.awvalid = 1'b0; bus.wdata = 32'd0;
        bus.wstrb = 4'd0; bus.wvalid = 1'b0; bus.bready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'd0);
        chk("rst_valids", 32'({bus.rvalid, bus.bvalid}), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_resps", 32'({bus.rresp, bus.bresp}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'h7);

        // Basic write then read with single-cycle latency.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, resp);
        chk("wr1_lat", 32'(lat), 32'd1);
        chk("wr1_bresp", 32'(resp), 32'd0);
        do_read(32'h8000_0010, d, resp, lat);
        chk("rd1_lat", 32'(lat), 32'd1);
        chk("rd1_rdata", d, 32'hDEAD_BEEF);
        chk("rd1_rresp", 32'(resp), 32'd0);

        // Partial strobe merge, then an all-zero strobe that must change nothing.
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, lat, resp);
        do_write(32'h8000_0020, 32'h0000_AA00, 4'h2, lat, resp);
        do_read(32'h8000_0020, d, resp, lat);
        chk("strb_merge", d, 32'h1122_AA44);
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, lat, resp);
        chk("strb0_bresp", 32'(resp), 32'd0);
        do_read(32'h8000_0020, d, resp, lat);
        chk("strb0_unchanged", d, 32'h1122_AA44);

        // W arrives three cycles before AW.
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        chk("wfirst_wready", 32'(bus.wready), 32'd1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        @(negedge clk);
        chk("wfirst_readies", 32'({bus.awready, bus.wready}), 32'h2);
        repeat (2) @(posedge clk);
        #1;
        chk("wfirst_no_bvalid", 32'(bus.bvalid), 32'd0);
        bus.awaddr = 32'h8000_0033; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.bvalid && lat < 20) begin @(negedge clk); lat++; end
        chk("wfirst_lat", 32'(lat), 32'd1);
        chk("wfirst_bresp", 32'(bus.bresp), 32'd0);
        @(posedge clk); #1;
        do_read(32'h8000_0030, d, resp, lat);
        chk("wfirst_data", d, 32'hCAFE_F00D);

        // Out-of-range accesses and the last in-range word.
        do_read(32'h7FFF_FFFC, d, resp, lat);
        chk("oor_rd_resp", 32'(resp), 32'd2);
        chk("oor_rd_data", d, 32'd0);
        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, lat, resp);
        do_write(32'h8000_4000, 32'h1234_5678, 4'hF, lat, resp);
        chk("oor_wr_resp", 32'(resp), 32'd2);
        do_read(32'h8000_0000, d, resp, lat);
        chk("oor_wr_no_alias", d, 32'h0BAD_F00D);
        do_write(32'h8000_3FFC, 32'h5A5A_0001, 4'hF, lat, resp);
        chk("last_wr_resp", 32'(resp), 32'd0);
        do_read(32'h8000_3FFC, d, resp, lat);
        chk("last_rd_data", d, 32'h5A5A_0001);

        // Simultaneous read and write requests: read wins, write waits.
        bus.araddr = 32'h8000_0010; bus.arvalid = 1'b1; bus.rready = 1'b1;
        bus.awaddr = 32'h8000_0040; bus.awvalid = 1'b1;
        bus.wdata = 32'h55AA_55AA; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        chk("prio_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'h4);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        chk("prio_busy_readies", 32'({bus.awready, bus.wready}), 32'd0);
        @(negedge clk);
        chk("prio_rvalid", 32'(bus.rvalid), 32'd1);
        chk("prio_rdata", bus.rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prio_wr_ready", 32'({bus.rvalid, bus.awready, bus.wready}), 32'h3);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.bvalid && lat < 20) begin @(negedge clk); lat++; end
        chk("prio_wr_lat", 32'(lat), 32'd1);
        @(posedge clk); #1;
        do_read(32'h8000_0040, d, resp, lat);
        chk("prio_wr_data", d, 32'h55AA_55AA);

        // Response held while rready stays low.
        bus.araddr = 32'h8000_0020; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rvalid", 32'(bus.rvalid), 32'd1);
            chk("hold_rdata", bus.rdata, 32'h1122_AA44);
            @(posedge clk);
        end
        #1;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_release", 32'(bus.rvalid), 32'd0);

        // Reset while a read is waiting drops it silently.
        bus.araddr = 32'h8000_0010; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", 32'({bus.arready, bus.awready, bus.wready, bus.rvalid}), 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_no_rvalid", 32'(bus.rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_readies", 32'({bus.arready, bus.rvalid}), 32'd0);
        do_read(32'h8000_0010, d, resp, lat);
        chk("rst_after_rd", d, 32'hDEAD_BEEF);
        chk("rst_after_resp", 32'(resp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
